// File: rtl/data_mem_arbiter_if.sv
// Bundle of requester, status and memory-side signals for data_mem_arbiter.
// slave is the arbiter's view; master is the environment's view (CPU, DMA and memory).
// Widths follow the AW/DW parameters of the instance.
interface data_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // Requester side
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          done0;
  logic          done1;
  logic [DW-1:0] rdata;
  logic          busy;

  // Memory side
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output done0, done1, rdata, busy, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  done0, done1, rdata, busy, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Purpose: shares one single-port data memory between the CPU (port 0) and DMA/debug (port 1); round-robin ties, or port-0 fixed priority when ARB_FIXED_PRIO_EN is defined.
// Latency: request sampled in IDLE -> memory driven for one cycle (ACCESS) -> done pulse the next cycle (2 cycles); one access per 3 cycles.
// Backpressure: one access in flight; the losing or late requester simply keeps req high until its own done.
module data_mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Everything the winning requester presented, frozen for the whole access.
  typedef struct packed {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  state_t        state_q;
  state_t        state_d;
  op_t           op_q;
  op_t           op_d;
  logic          last_served_q;
  logic          grant;
  logic          load;
  logic [DW-1:0] rdata_q;

  // Next-state logic and winner selection; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    grant   = !bus.req0;
`else
    grant   = (bus.req0 && bus.req1) ? ~last_served_q : !bus.req0;
`endif
    op_d.port  = grant;
    op_d.we    = grant ? bus.we1    : bus.we0;
    op_d.addr  = grant ? bus.addr1  : bus.addr0;
    op_d.wdata = grant ? bus.wdata1 : bus.wdata0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          load    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winner's operation and remember who was served; last_served starts at 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q          <= '0;
      last_served_q <= 1'b1;
    end else if (load) begin
      op_q          <= op_d;
      last_served_q <= grant;
    end
  end

  // Capture read data at the end of a read ACCESS; held across writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (state_q == ACCESS && !op_q.we) begin
      rdata_q <= bus.mem_rdata;
    end
  end

  // Outputs decode straight from state so a reset mid-access kills mem_we immediately.
  assign bus.mem_we    = (state_q == ACCESS) && op_q.we;
  assign bus.mem_addr  = op_q.addr;
  assign bus.mem_wdata = op_q.wdata;
  assign bus.done0     = (state_q == DONE) && !op_q.port;
  assign bus.done1     = (state_q == DONE) && op_q.port;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rdata     = rdata_q;

endmodule
